// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and helpers for the sprite line fetcher.
// Optional horizontal flip support is controlled by the SPRITE_HFLIP_EN macro.
package sprite_pkg;

  localparam int SPR_SIZE    = 16;
  localparam int SPR_COORD_W = 4;
  localparam int SPR_SEL_W   = 6;
  localparam int SPR_PIX_W   = 2;

  localparam logic [SPR_PIX_W-1:0] SPR_TRANSPARENT = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_e;

  // Mirrored column of a 16-wide pattern: 15 - col is the bitwise inverse.
  function automatic logic [SPR_COORD_W-1:0] spr_col_addr(
    input logic [SPR_COORD_W-1:0] col,
    input logic                   flip
  );
    return flip ? ~col : col;
  endfunction

endpackage

// File: rtl/sprite_line_fetcher_if.sv
// Bundle of line control, object table, pattern memory and line buffer signals.
// The obj_flip member only exists when SPRITE_HFLIP_EN is defined.
interface sprite_line_fetcher_if
  import sprite_pkg::*;
#(
  parameter int NUM_OBJ = 8,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
);

  localparam int IDX_W = $clog2(NUM_OBJ);

  logic                   line_start;
  logic [Y_W-1:0]         line_num;
  logic                   obj_we;
  logic [IDX_W-1:0]       obj_idx;
  logic                   obj_en;
  logic [X_W-1:0]         obj_x;
  logic [Y_W-1:0]         obj_y;
  logic [SPR_SEL_W-1:0]   obj_sel;
`ifdef SPRITE_HFLIP_EN
  logic                   obj_flip;
`endif
  logic [SPR_SEL_W-1:0]   mem_select;
  logic [SPR_COORD_W-1:0] mem_x;
  logic [SPR_COORD_W-1:0] mem_y;
  logic [SPR_PIX_W-1:0]   mem_pixel;
  logic                   lb_we;
  logic [X_W-1:0]         lb_addr;
  logic [SPR_PIX_W-1:0]   lb_data;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  modport slave (
    input  line_start, line_num, obj_we, obj_idx, obj_en, obj_x, obj_y, obj_sel,
`ifdef SPRITE_HFLIP_EN
    input  obj_flip,
`endif
    input  mem_pixel,
    output mem_select, mem_x, mem_y, lb_we, lb_addr, lb_data, busy, done, overflow
  );

  modport master (
    output line_start, line_num, obj_we, obj_idx, obj_en, obj_x, obj_y, obj_sel,
`ifdef SPRITE_HFLIP_EN
    output obj_flip,
`endif
    output mem_pixel,
    input  mem_select, mem_x, mem_y, lb_we, lb_addr, lb_data, busy, done, overflow
  );

endinterface

// File: rtl/sprite_obj_table.sv
// Object table: one write port, one combinational indexed read port.
// Per-entry flip bit is stored only when SPRITE_HFLIP_EN is defined.
module sprite_obj_table
  import sprite_pkg::*;
#(
  parameter int NUM_OBJ = 8,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [$clog2(NUM_OBJ)-1:0] wr_idx_i,
  input  logic                       wr_obj_en_i,
  input  logic [X_W-1:0]             wr_x_i,
  input  logic [Y_W-1:0]             wr_y_i,
  input  logic [SPR_SEL_W-1:0]       wr_sel_i,
`ifdef SPRITE_HFLIP_EN
  input  logic                       wr_flip_i,
  output logic                       rd_flip_o,
`endif
  input  logic [$clog2(NUM_OBJ)-1:0] rd_idx_i,
  output logic                       rd_en_o,
  output logic [X_W-1:0]             rd_x_o,
  output logic [Y_W-1:0]             rd_y_o,
  output logic [SPR_SEL_W-1:0]       rd_sel_o
);

  logic [NUM_OBJ-1:0]   en_q;
  logic [X_W-1:0]       x_q   [NUM_OBJ];
  logic [Y_W-1:0]       y_q   [NUM_OBJ];
  logic [SPR_SEL_W-1:0] sel_q [NUM_OBJ];
`ifdef SPRITE_HFLIP_EN
  logic [NUM_OBJ-1:0]   flip_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        sel_q[i] <= '0;
      end
`ifdef SPRITE_HFLIP_EN
      flip_q <= '0;
`endif
    end else if (wr_en_i) begin
      en_q[wr_idx_i]  <= wr_obj_en_i;
      x_q[wr_idx_i]   <= wr_x_i;
      y_q[wr_idx_i]   <= wr_y_i;
      sel_q[wr_idx_i] <= wr_sel_i;
`ifdef SPRITE_HFLIP_EN
      flip_q[wr_idx_i] <= wr_flip_i;
`endif
    end
  end

  assign rd_en_o  = en_q[rd_idx_i];
  assign rd_x_o   = x_q[rd_idx_i];
  assign rd_y_o   = y_q[rd_idx_i];
  assign rd_sel_o = sel_q[rd_idx_i];
`ifdef SPRITE_HFLIP_EN
  assign rd_flip_o = flip_q[rd_idx_i];
`endif

endmodule

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite scheduler: scans the object table, fetches pattern rows and
// writes opaque pixels to the line buffer. SPRITE_HFLIP_EN adds per-object mirroring.
//
// state | meaning
// IDLE  | waiting for line_start
// SCAN  | one table entry per cycle, collecting hits into the found list
// FETCH | 16 pattern reads per found entry, highest table index first
// DRAIN | last pattern read still in flight
// DONE  | done pulse, then back to IDLE
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter int NUM_OBJ      = 8,
  parameter int MAX_PER_LINE = 4,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int SCREEN_W     = 640
) (
  input logic clock,
  input logic reset,
  sprite_line_fetcher_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_OBJ);
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
  localparam int PTR_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int AW    = X_W + 1;

  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_OBJ - 1);
  localparam logic [CNT_W-1:0]       MAX_CNT    = CNT_W'(MAX_PER_LINE);
  localparam logic [AW-1:0]          SCREEN_LIM = AW'(SCREEN_W);
  localparam logic [SPR_COORD_W-1:0] LAST_COL   = SPR_COORD_W'(SPR_SIZE - 1);

  fetch_state_e state_q;
  logic [IDX_W-1:0] idx_q;
  logic [Y_W-1:0]   line_q;
  logic [CNT_W-1:0] found_q;
  logic [PTR_W-1:0] ptr_q;
  logic [SPR_COORD_W-1:0] col_q;
  logic [X_W-1:0]   cur_x_q;

  logic [SPR_SEL_W-1:0]   fl_sel_q [MAX_PER_LINE];
  logic [X_W-1:0]         fl_x_q   [MAX_PER_LINE];
  logic [SPR_COORD_W-1:0] fl_row_q [MAX_PER_LINE];

  logic [SPR_SEL_W-1:0]   mem_select_q;
  logic [SPR_COORD_W-1:0] mem_x_q;
  logic [SPR_COORD_W-1:0] mem_y_q;
  logic [AW-1:0]          issue_addr_q;
  logic                   pend_valid_q;
  logic [AW-1:0]          pend_addr_q;
  logic                   lb_we_q;
  logic [X_W-1:0]         lb_addr_q;
  logic [SPR_PIX_W-1:0]   lb_data_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   overflow_q;

  logic                 rd_en;
  logic [X_W-1:0]       rd_x;
  logic [Y_W-1:0]       rd_y;
  logic [SPR_SEL_W-1:0] rd_sel;
  logic                 cur_flip;

`ifdef SPRITE_HFLIP_EN
  logic                    rd_flip;
  logic [MAX_PER_LINE-1:0] fl_flip_q;
  logic                    cur_flip_q;
  assign cur_flip = cur_flip_q;
`else
  assign cur_flip = 1'b0;
`endif

  sprite_obj_table #(
    .NUM_OBJ (NUM_OBJ),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_obj_table (
    .clock       (clock),
    .reset       (reset),
    .wr_en_i     (bus.obj_we),
    .wr_idx_i    (bus.obj_idx),
    .wr_obj_en_i (bus.obj_en),
    .wr_x_i      (bus.obj_x),
    .wr_y_i      (bus.obj_y),
    .wr_sel_i    (bus.obj_sel),
`ifdef SPRITE_HFLIP_EN
    .wr_flip_i   (bus.obj_flip),
    .rd_flip_o   (rd_flip),
`endif
    .rd_idx_i    (idx_q),
    .rd_en_o     (rd_en),
    .rd_x_o      (rd_x),
    .rd_y_o      (rd_y),
    .rd_sel_o    (rd_sel)
  );

  // Modular line distance; objects above the line wrap to large values and miss.
  logic [Y_W-1:0]   diff;
  logic             hit;
  logic             push;
  logic [CNT_W-1:0] found_m1;
  logic [SPR_COORD_W-1:0] col_nx;
  logic             pix_write;

  assign diff      = line_q - rd_y;
  assign hit       = rd_en && (diff[Y_W-1:SPR_COORD_W] == '0);
  assign push      = (state_q == SCAN) && hit && (found_q < MAX_CNT);
  assign found_m1  = found_q - CNT_W'(1);
  assign col_nx    = col_q + SPR_COORD_W'(1);
  assign pix_write = pend_valid_q && (bus.mem_pixel != SPR_TRANSPARENT) &&
                     (pend_addr_q < SCREEN_LIM);

  // Next entry to fetch: at the end of SCAN the newest hit may still be in flight.
  logic [PTR_W-1:0]       ld_idx;
  logic [PTR_W-1:0]       ld_ptr;
  logic [SPR_SEL_W-1:0]   ld_sel;
  logic [X_W-1:0]         ld_x;
  logic [SPR_COORD_W-1:0] ld_row;
  logic                   ld_flip;

  always_comb begin
    ld_idx  = (state_q == SCAN) ? found_m1[PTR_W-1:0] : (ptr_q - PTR_W'(1));
    ld_ptr  = ld_idx;
    ld_sel  = fl_sel_q[ld_idx];
    ld_x    = fl_x_q[ld_idx];
    ld_row  = fl_row_q[ld_idx];
    ld_flip = 1'b0;
`ifdef SPRITE_HFLIP_EN
    ld_flip = fl_flip_q[ld_idx];
`endif
    if (push) begin
      ld_ptr = found_q[PTR_W-1:0];
      ld_sel = rd_sel;
      ld_x   = rd_x;
      ld_row = diff[SPR_COORD_W-1:0];
`ifdef SPRITE_HFLIP_EN
      ld_flip = rd_flip;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      line_q       <= '0;
      found_q      <= '0;
      ptr_q        <= '0;
      col_q        <= '0;
      cur_x_q      <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        fl_sel_q[i] <= '0;
        fl_x_q[i]   <= '0;
        fl_row_q[i] <= '0;
      end
`ifdef SPRITE_HFLIP_EN
      fl_flip_q    <= '0;
      cur_flip_q   <= 1'b0;
`endif
      mem_select_q <= '0;
      mem_x_q      <= '0;
      mem_y_q      <= '0;
      issue_addr_q <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      lb_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pend_valid_q <= (state_q == FETCH);
      pend_addr_q  <= issue_addr_q;
      lb_we_q      <= pix_write;
      if (pix_write) begin
        lb_addr_q <= pend_addr_q[X_W-1:0];
        lb_data_q <= bus.mem_pixel;
      end
      done_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (bus.line_start) begin
            state_q    <= SCAN;
            idx_q      <= '0;
            found_q    <= '0;
            overflow_q <= 1'b0;
            line_q     <= bus.line_num;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          if (push) begin
            fl_sel_q[found_q[PTR_W-1:0]] <= rd_sel;
            fl_x_q[found_q[PTR_W-1:0]]   <= rd_x;
            fl_row_q[found_q[PTR_W-1:0]] <= diff[SPR_COORD_W-1:0];
`ifdef SPRITE_HFLIP_EN
            fl_flip_q[found_q[PTR_W-1:0]] <= rd_flip;
`endif
            found_q <= found_q + CNT_W'(1);
          end else if (hit) begin
            overflow_q <= 1'b1;
          end
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            if ((found_q == '0) && !push) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= FETCH;
              ptr_q        <= ld_ptr;
              col_q        <= '0;
              mem_select_q <= ld_sel;
              mem_y_q      <= ld_row;
              mem_x_q      <= spr_col_addr('0, ld_flip);
              cur_x_q      <= ld_x;
              issue_addr_q <= AW'(ld_x);
`ifdef SPRITE_HFLIP_EN
              cur_flip_q   <= ld_flip;
`endif
            end
          end
        end
        FETCH: begin
          if (col_q == LAST_COL) begin
            if (ptr_q == '0) begin
              state_q <= DRAIN;
            end else begin
              ptr_q        <= ld_ptr;
              col_q        <= '0;
              mem_select_q <= ld_sel;
              mem_y_q      <= ld_row;
              mem_x_q      <= spr_col_addr('0, ld_flip);
              cur_x_q      <= ld_x;
              issue_addr_q <= AW'(ld_x);
`ifdef SPRITE_HFLIP_EN
              cur_flip_q   <= ld_flip;
`endif
            end
          end else begin
            col_q        <= col_nx;
            mem_x_q      <= spr_col_addr(col_nx, cur_flip);
            issue_addr_q <= AW'(cur_x_q) + AW'(col_nx);
          end
        end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_select = mem_select_q;
  assign bus.mem_x      = mem_x_q;
  assign bus.mem_y      = mem_y_q;
  assign bus.lb_we      = lb_we_q;
  assign bus.lb_addr    = lb_addr_q;
  assign bus.lb_data    = lb_data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;

endmodule
